router_port_rx: RTL and testbench
=================================

# router_port_rx

Output-port receiver for the 16-port router bench. It watches one router output port (`frameo_n`, `valido_n`, `dout`), turns the serial LSB-first bitstream back into bytes, and marks packet boundaries. Completed bytes go into a small FIFO with a valid/ready consumer port, so scoreboards and checkers read whole bytes, not bits. Sixteen instances, one per port, form the receive half of the environment; it is the counterpart of the input-side driver.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in bytes (power of two, ≥2).
- `CNT_W`, 16: width of the packet counter.

Ports:
- `clock`  in  1: single clock; all logic on posedge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `frameo_n`  in  1: router frame strobe for this port, active low.
- `valido_n`  in  1: router bit-valid strobe, active low.
- `dout`  in  1: router serial data bit.
- `rx_data`  out  8: FIFO head byte.
- `rx_last`  out  1: FIFO head byte is the final byte of its packet.
- `rx_valid`  out  1: FIFO non-empty.
- `rx_ready`  in  1: consumer accepts the head byte when `rx_valid & rx_ready`.
- `rx_busy`  out  1: receiver is not in IDLE.
- `pkt_cnt`  out  CNT_W: count of packets received cleanly; wraps.
- `err_partial`  out  1: one-cycle pulse when a frame ends on a non-byte boundary.
- `err_overflow`  out  1: one-cycle pulse when a byte is dropped because the FIFO is full.
- `err_frame`  out  1: one-cycle pulse when `frameo_n` rises with no final bit.

## Operation
- States: IDLE, RECV, DROP.
- Bit accept:
  - A bit is accepted when `valido_n==0` and either `frameo_n==0` or the state is RECV.
  - Each accepted bit shifts into bit position `bit_cnt` (LSB first).
  - `bit_cnt` is 3 bits and wraps from 7 to 0.
  - The end bit is an accepted bit with `frameo_n==1`.
- IDLE:
  - `frameo_n==0` moves to RECV. A bit accepted in that same cycle is kept.
  - Strobes seen while `frameo_n==1` are ignored.
- RECV, byte completion:
  - When `bit_cnt==7` and a bit is accepted, push {last, byte}.
  - last = 1 if this is the end bit, else 0.
- RECV, end bit:
  - On a byte boundary: push as above, increment `pkt_cnt`, go to IDLE.
  - Not on a byte boundary: push the partial byte zero-filled in the upper bits with last=1, pulse `err_partial`, do not increment `pkt_cnt`, go to IDLE.
- RECV, frame loss: `frameo_n==1 && valido_n==1` discards the partial byte, pulses `err_frame`, and goes to IDLE. A zero-bit frame also takes this path.
- Overflow:
  - A push while the FIFO is full and no pop occurs that cycle drops the byte and pulses `err_overflow`.
  - Then RECV moves to DROP. If the dropped push was the end bit, go to IDLE instead.
  - Bytes already stored stay in the FIFO; the packet is incomplete (no last byte).
- DROP: ignore bits until the end bit or frame loss, then go to IDLE with no further pulses.
- Full plus pop: a push is accepted when the FIFO is full and `rx_valid & rx_ready` in the same cycle.
- `rx_busy` = (state != IDLE).

## Timing
- Reset values: `rx_valid`=0, `rx_data`=0, `rx_last`=0, `rx_busy`=0, `pkt_cnt`=0, all error pulses 0, `bit_cnt`=0, state IDLE, FIFO empty.
- Reset is asynchronous and takes effect mid-packet. After reset, reception resumes only at the next falling `frameo_n` seen in IDLE.
- Inputs are synchronous to `clock` and are sampled directly, with no synchronizers.
- Push latency: the byte completed at edge N is visible as `rx_valid`/`rx_data` after edge N (first cycle after the eighth bit). This assumes the FIFO was empty.
- `rx_data`/`rx_last` are driven combinationally from the FIFO head register. They stay stable while `rx_valid & !rx_ready`.
- Error pulses and `pkt_cnt` update on the same edge as the triggering bit.

## Structure
- Package `router_rx_pkg`:
  - `rx_state_t` enum {IDLE, RECV, DROP}.
  - `BYTE_W`=8.
  - Packed struct `rx_entry_t` {last, data[7:0]}.
- Sub-module `router_rx_fifo`:
  - Synchronous FIFO of `rx_entry_t` with DEPTH parameter.
  - Push/pop with full/empty flags; push allowed on full only with a simultaneous pop.
- Top level holds the FSM, shift register, bit counter, packet counter and error pulses.

## Test plan
- Two-byte packet 0xA5, 0x3C, continuous strobes, `rx_ready`=1 → bytes A5/last=0 then 3C/last=1; `pkt_cnt`=1; no errors; `rx_busy` low after the end bit.
- Same packet with `valido_n` high for 3 cycles after bit 5 and for 2 cycles after bit 11 → identical bytes and `pkt_cnt`=1.
- 12-bit packet 0xABC → bytes BC/last=0 and 0A/last=1; `err_partial` pulses once; `pkt_cnt` unchanged.
- DEPTH=16, `rx_ready`=0, 20-byte packet → 16 bytes held; `err_overflow` pulses once; `rx_busy` stays high until the end bit. Then drain, send 1-byte 0x55 → 55/last=1, `pkt_cnt`=1.
- `frameo_n` rises with `valido_n` high after 10 bits → one byte pushed, last=0; `err_frame` pulse; state IDLE.
- `reset_n` low mid-packet (FIFO holding 3 bytes) → all outputs reset immediately, FIFO empty. Next packet 0x7E → 7E/last=1, `pkt_cnt`=1.

Source files
------------

// File: rtl/router_rx_pkg.sv
// Shared types for the router output-port receiver: FSM states and FIFO entry layout.
package router_rx_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/router_rx_fifo.sv
// Byte FIFO between the bit deserializer and the valid/ready consumer port.
// A push on full is taken only when a pop frees a slot in the same cycle.
module router_rx_fifo
    import router_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      push,
    input  rx_entry_t push_entry,
    input  logic      pop,
    output rx_entry_t head,
    output logic      empty,
    output logic      full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    rx_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_en;
    logic        rd_en;

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array has no reset; only the pointers need one, and the
    // head is gated to zero while empty so no stale entry is ever visible.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/router_port_rx.sv
// Receiver for one router output port: deserializes the LSB-first bitstream into
// bytes, tags packet ends, and queues them for a valid/ready consumer.
module router_port_rx
    import router_rx_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              frameo_n,
    input  logic              valido_n,
    input  logic              dout,
    output logic [7:0]        rx_data,
    output logic              rx_last,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_busy,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic              err_partial,
    output logic              err_overflow,
    output logic              err_frame
);

    rx_state_t         state;
    rx_state_t         state_next;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_cnt_next;
    logic [BYTE_W-1:0] shift_reg;
    logic [BYTE_W-1:0] shift_next;
    logic [BYTE_W-1:0] cur_byte;
    logic              push_req;
    rx_entry_t         push_entry;
    logic              pkt_inc;
    logic              err_partial_next;
    logic              err_overflow_next;
    logic              err_frame_next;

    rx_entry_t         head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              fifo_room;

    assign rx_valid  = !fifo_empty;
    assign rx_data   = head.data;
    assign rx_last   = head.last;
    assign pop       = rx_valid && rx_ready;
    assign fifo_room = !fifo_full || pop;
    assign rx_busy   = (state != IDLE);

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_next        = state;
        bit_cnt_next      = bit_cnt;
        shift_next        = shift_reg;
        push_req          = 1'b0;
        push_entry        = '0;
        pkt_inc           = 1'b0;
        err_partial_next  = 1'b0;
        err_overflow_next = 1'b0;
        err_frame_next    = 1'b0;

        cur_byte          = shift_reg;
        cur_byte[bit_cnt] = dout;

        case (state)
            IDLE: begin
                if (!frameo_n) begin
                    state_next = RECV;
                    if (!valido_n) begin
                        shift_next   = cur_byte;
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end

            RECV: begin
                if (frameo_n && valido_n) begin
                    err_frame_next = 1'b1;
                    state_next     = IDLE;
                    shift_next     = '0;
                    bit_cnt_next   = '0;
                end else if (!valido_n) begin
                    if (bit_cnt == 3'd7 || frameo_n) begin
                        // Full byte, or the end bit closing a short zero-filled byte.
                        push_req        = 1'b1;
                        push_entry.last = frameo_n;
                        push_entry.data = cur_byte;
                        shift_next      = '0;
                        bit_cnt_next    = '0;
                        if (frameo_n) begin
                            state_next = IDLE;
                            if (bit_cnt != 3'd7) err_partial_next = 1'b1;
                            else if (fifo_room)  pkt_inc          = 1'b1;
                        end
                        if (!fifo_room) begin
                            err_overflow_next = 1'b1;
                            if (!frameo_n) state_next = DROP;
                        end
                    end else begin
                        shift_next   = cur_byte;
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end

            DROP: begin
                // End bit or frame loss both show up as frameo_n high.
                if (frameo_n) state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            pkt_cnt      <= '0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
            err_frame    <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            shift_reg    <= shift_next;
            err_partial  <= err_partial_next;
            err_overflow <= err_overflow_next;
            err_frame    <= err_frame_next;
            if (pkt_inc) pkt_cnt <= pkt_cnt + CNT_W'(1);
        end
    end

    router_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push_req && fifo_room),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

endmodule

// File: tb/tb_router_port_rx.sv
// Self-checking bench for router_port_rx: directed packets plus randomized traffic
// compared each cycle against a bit-queue/byte-queue reference model.
module tb_router_port_rx;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             clock;
    logic             reset_n;
    logic             frameo_n;
    logic             valido_n;
    logic             dout;
    logic [7:0]       rx_data;
    logic             rx_last;
    logic             rx_valid;
    logic             rx_ready;
    logic             rx_busy;
    logic [CNT_W-1:0] pkt_cnt;
    logic             err_partial;
    logic             err_overflow;
    logic             err_frame;

    router_port_rx #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .frameo_n     (frameo_n),
        .valido_n     (valido_n),
        .dout         (dout),
        .rx_data      (rx_data),
        .rx_last      (rx_last),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_busy      (rx_busy),
        .pkt_cnt      (pkt_cnt),
        .err_partial  (err_partial),
        .err_overflow (err_overflow),
        .err_frame    (err_frame)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_mis = 0;
    int          n_ep  = 0;
    int          n_eo  = 0;
    int          n_ef  = 0;
    int unsigned rdy_pct = 100;
    logic [8:0]  got[$];

    // Reference model: a frame is a list of bits; every 8 bits, or the end bit,
    // closes a byte; the FIFO is a bounded queue of {last, data}.
    bit              m_in_frame;
    bit              m_drop;
    bit              m_bits[$];
    logic [8:0]      m_fifo[$];
    logic [CNT_W-1:0] m_pkt;
    bit              m_ep, m_eo, m_ef;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_in_frame = 0;
        m_drop     = 0;
        m_bits.delete();
        m_fifo.delete();
        m_pkt      = '0;
        m_ep       = 0;
        m_eo       = 0;
        m_ef       = 0;
    endfunction

    function automatic void model_step(input bit f, input bit v, input bit d, input bit r);
        bit         pop;
        bit         room;
        logic [8:0] e;
        int         n;
        m_ep = 0;
        m_eo = 0;
        m_ef = 0;
        pop  = r && (m_fifo.size() > 0);
        room = (m_fifo.size() < DEPTH) || pop;
        if (pop) void'(m_fifo.pop_front());
        if (!m_in_frame) begin
            if (!f) begin
                m_in_frame = 1;
                m_drop     = 0;
                m_bits.delete();
                if (!v) m_bits.push_back(d);
            end
        end else if (m_drop) begin
            if (f) m_in_frame = 0;
        end else if (f && v) begin
            m_ef       = 1;
            m_in_frame = 0;
            m_bits.delete();
        end else if (!v) begin
            m_bits.push_back(d);
            if (m_bits.size() == 8 || f) begin
                n = m_bits.size();
                e = {f, 8'h00};
                for (int i = 0; i < n; i++) e[i] = m_bits[i];
                m_bits.delete();
                if (room) m_fifo.push_back(e);
                else begin
                    m_eo = 1;
                    if (!f) m_drop = 1;
                end
                if (f) begin
                    m_in_frame = 0;
                    if (n != 8) m_ep = 1;
                    else if (room) m_pkt = m_pkt + 1'b1;
                end
            end
        end
    endfunction

    task automatic compare();
        check("rx_valid", rx_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) begin
            check("rx_data", rx_data, m_fifo[0][7:0]);
            check("rx_last", rx_last, m_fifo[0][8]);
        end
        check("rx_busy", rx_busy, m_in_frame);
        check("pkt_cnt", pkt_cnt, m_pkt);
        check("err_partial", err_partial, m_ep);
        check("err_overflow", err_overflow, m_eo);
        check("err_frame", err_frame, m_ef);
        if (err_partial)  n_ep++;
        if (err_overflow) n_eo++;
        if (err_frame)    n_ef++;
    endtask

    function automatic bit rdy_now();
        return $urandom_range(0, 99) < rdy_pct;
    endfunction

    task automatic step(input bit f, input bit v, input bit d);
        bit r;
        r        = rdy_now();
        frameo_n = f;
        valido_n = v;
        dout     = d;
        rx_ready = r;
        if (rx_valid && r) got.push_back({rx_last, rx_data});
        model_step(f, v, d, r);
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic send_pkt(input logic [255:0] data, input int nbits,
                            input int s1_at, input int s1_len,
                            input int s2_at, input int s2_len, input bit lose);
        bit endb;
        if (nbits == 0) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            endb = !lose && (i == nbits - 1);
            step(endb, 1'b0, data[i]);
            if (!endb && i == s1_at) repeat (s1_len) step(1'b0, 1'b1, 1'b0);
            if (!endb && i == s2_at) repeat (s2_len) step(1'b0, 1'b1, 1'b0);
        end
        if (lose) step(1'b1, 1'b1, 1'b0);
        idle(2);
    endtask

    task automatic clear_log();
        got.delete();
        n_ep = 0;
        n_eo = 0;
        n_ef = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_data", rx_data, 0);
        check("rst rx_last", rx_last, 0);
        check("rst rx_busy", rx_busy, 0);
        check("rst pkt_cnt", pkt_cnt, 0);
        check("rst errors", {err_partial, err_overflow, err_frame}, 0);
    endtask

    initial begin
        logic [255:0] data;
        int           nbits;
        bit           lose;

        reset_n  = 1'b1;
        frameo_n = 1'b1;
        valido_n = 1'b1;
        dout     = 1'b0;
        rx_ready = 1'b1;
        model_reset();
        #2 reset_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2);

        // Two-byte packet, continuous strobes.
        clear_log();
        send_pkt(256'h3CA5, 16, -1, 0, -1, 0, 1'b0);
        check("p1 count", got.size(), 2);
        if (got.size() == 2) begin
            check("p1 byte0", got[0], 9'h0A5);
            check("p1 byte1", got[1], 9'h13C);
        end
        check("p1 pkt_cnt", pkt_cnt, 1);
        check("p1 errors", n_ep + n_eo + n_ef, 0);
        check("p1 busy", rx_busy, 0);

        // Same packet with valid gaps.
        clear_log();
        send_pkt(256'h3CA5, 16, 5, 3, 11, 2, 1'b0);
        check("p2 count", got.size(), 2);
        if (got.size() == 2) begin
            check("p2 byte0", got[0], 9'h0A5);
            check("p2 byte1", got[1], 9'h13C);
        end
        check("p2 pkt_cnt", pkt_cnt, 2);

        // 12-bit packet ends mid-byte.
        clear_log();
        send_pkt(256'hABC, 12, -1, 0, -1, 0, 1'b0);
        check("p3 count", got.size(), 2);
        if (got.size() == 2) begin
            check("p3 byte0", got[0], 9'h0BC);
            check("p3 byte1", got[1], 9'h10A);
        end
        check("p3 partial", n_ep, 1);
        check("p3 pkt_cnt", pkt_cnt, 2);

        // Overflow: 20 bytes into a stalled 16-deep FIFO, then drain.
        clear_log();
        rdy_pct = 0;
        for (int i = 0; i < 8; i++) data[i*32 +: 32] = $urandom;
        send_pkt(data, 160, -1, 0, -1, 0, 1'b0);
        check("p4 overflow", n_eo, 1);
        check("p4 valid", rx_valid, 1);
        rdy_pct = 100;
        idle(20);
        check("p4 drained", got.size(), 16);
        if (got.size() == 16) begin
            check("p4 first", got[0], {1'b0, data[7:0]});
            check("p4 tail", got[15], {1'b0, data[127:120]});
        end
        check("p4 pkt_cnt", pkt_cnt, 2);
        clear_log();
        send_pkt(256'h55, 8, -1, 0, -1, 0, 1'b0);
        check("p5 byte", got.size() == 1 ? got[0] : 9'h1FF, 9'h155);
        check("p5 pkt_cnt", pkt_cnt, 3);

        // Frame loss after 10 bits.
        clear_log();
        send_pkt(256'h3A7, 10, -1, 0, -1, 0, 1'b1);
        check("p6 byte", got.size() == 1 ? got[0] : 9'h1FF, 9'h0A7);
        check("p6 err_frame", n_ef, 1);
        check("p6 busy", rx_busy, 0);

        // Asynchronous reset mid-packet with 3 bytes queued.
        clear_log();
        rdy_pct = 0;
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'($urandom));
        check("p7 held", rx_valid, 1);
        #2 reset_n = 1'b0;
        frameo_n = 1'b1;
        valido_n = 1'b1;
        #1 check_reset_outputs();
        model_reset();
        @(posedge clock);
        #3 reset_n = 1'b1;
        rdy_pct = 100;
        idle(2);
        send_pkt(256'h7E, 8, -1, 0, -1, 0, 1'b0);
        check("p7 byte", got.size() == 1 ? got[0] : 9'h1FF, 9'h17E);
        check("p7 pkt_cnt", pkt_cnt, 1);

        // Randomized traffic.
        for (int p = 0; p < 250; p++) begin
            case ($urandom_range(0, 2))
                0:       rdy_pct = 100;
                1:       rdy_pct = 50;
                default: rdy_pct = 8;
            endcase
            for (int i = 0; i < 8; i++) data[i*32 +: 32] = $urandom;
            nbits = ($urandom_range(0, 7) == 0) ? $urandom_range(120, 200) : $urandom_range(1, 48);
            lose  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) begin
                nbits = 0;
                lose  = 1;
            end
            send_pkt(data, nbits, $urandom_range(0, 40), $urandom_range(0, 3),
                     $urandom_range(0, 40), $urandom_range(0, 3), lose);
            repeat ($urandom_range(0, 3)) step(1'b1, 1'($urandom), 1'($urandom));
        end
        rdy_pct = 100;
        idle(20);
        check("final empty", rx_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
